key_event_scheduler: RTL

//  Consumes N debounced, active-low key levels (bd_tx of each debouncer) and turns each into

---
 rtl/key_event_scheduler.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/key_event_scheduler.sv
// Turns debounced active-low key levels into SHORT/LONG/REPEAT events and serializes them
// through a round-robin arbiter into a single first-word-fall-through event FIFO.
module key_event_scheduler #(
  parameter int N_KEYS     = 4,
  parameter int KEY_W      = 2,
  parameter int LONG_CYC   = 50000000,
  parameter int REP_CYC    = 10000000,
  parameter int CNT_W      = 26,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [N_KEYS-1:0] key_n,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [KEY_W-1:0]  ev_key,
  output logic [1:0]        ev_type,
  output logic              ev_overflow,
  input  logic              ovf_clr
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [1:0] EV_SHORT  = 2'b01;
  localparam logic [1:0] EV_LONG   = 2'b10;
  localparam logic [1:0] EV_REPEAT = 2'b11;

  typedef enum logic [1:0] {WAIT_REL, IDLE, HOLD, LONG_ST} kst_e;

  logic [N_KEYS-1:0] k_q;
  kst_e              st_q   [N_KEYS];
  kst_e              st_d   [N_KEYS];
  logic [CNT_W-1:0]  cnt_q  [N_KEYS];
  logic [CNT_W-1:0]  cnt_d  [N_KEYS];
  logic [N_KEYS-1:0] post;
  logic [1:0]        post_type [N_KEYS];
  logic [N_KEYS-1:0] pend_q, pend_d;
  logic [1:0]        ptype_q [N_KEYS];
  logic [1:0]        ptype_d [N_KEYS];
  logic [KEY_W-1:0]  rr_q, rr_d;
  logic              grant_vld;
  logic [KEY_W-1:0]  grant_idx;
  logic              drop;
  logic              ovf_q, ovf_d;
  logic [KEY_W-1:0]  mem_key_q  [FIFO_DEPTH];
  logic [1:0]        mem_type_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [PTR_W:0]    fcnt_q;
  logic              pop, full;

  function automatic logic [KEY_W-1:0] rr_idx(input logic [KEY_W-1:0] base, input int k);
    int j;
    j = int'(base) + k;
    if (j >= N_KEYS) j = j - N_KEYS;
    return KEY_W'(j);
  endfunction

  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      st_d[i]      = st_q[i];
      cnt_d[i]     = cnt_q[i];
      post[i]      = 1'b0;
      post_type[i] = 2'b00;
      if (!enable) begin
        st_d[i]  = WAIT_REL;
        cnt_d[i] = '0;
      end else begin
        case (st_q[i])
          WAIT_REL: if (k_q[i]) st_d[i] = IDLE;
          IDLE: begin
            if (!k_q[i]) begin
              st_d[i]  = HOLD;
              cnt_d[i] = '0;
            end
          end
          HOLD: begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
            // release takes priority over reaching the long threshold
            if (k_q[i]) begin
              post[i]      = 1'b1;
              post_type[i] = EV_SHORT;
              st_d[i]      = IDLE;
            end else if (cnt_q[i] == CNT_W'(LONG_CYC - 1)) begin
              post[i]      = 1'b1;
              post_type[i] = EV_LONG;
              st_d[i]      = LONG_ST;
              cnt_d[i]     = '0;
            end
          end
          default: begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
            if (k_q[i]) begin
              st_d[i] = IDLE;
            end else if (cnt_q[i] == CNT_W'(REP_CYC - 1)) begin
              post[i]      = 1'b1;
              post_type[i] = EV_REPEAT;
              cnt_d[i]     = '0;
            end
          end
        endcase
      end
    end
  end

  assign pop  = ev_valid & ev_ready;
  assign full = (fcnt_q == (PTR_W + 1)'(FIFO_DEPTH));

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (enable && (!full || pop)) begin
      for (int k = 0; k < N_KEYS; k++) begin
        if (!grant_vld && pend_q[rr_idx(rr_q, k)]) begin
          grant_vld = 1'b1;
          grant_idx = rr_idx(rr_q, k);
        end
      end
    end
    rr_d = rr_q;
    if (grant_vld) rr_d = rr_idx(grant_idx, 1);
  end

  always_comb begin
    drop  = 1'b0;
    ovf_d = ovf_q;
    for (int i = 0; i < N_KEYS; i++) begin
      pend_d[i]  = pend_q[i];
      ptype_d[i] = ptype_q[i];
      if (!enable) begin
        pend_d[i] = 1'b0;
      end else begin
        if (grant_vld && (grant_idx == KEY_W'(i))) pend_d[i] = 1'b0;
        if (post[i]) begin
          if (pend_d[i]) begin
            drop = 1'b1;
          end else begin
            pend_d[i]  = 1'b1;
            ptype_d[i] = post_type[i];
          end
        end
      end
    end
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  // Stage: input sample, pending types and FIFO storage (data, no reset)
  always_ff @(posedge clk) begin
    k_q <= key_n;
    for (int i = 0; i < N_KEYS; i++) ptype_q[i] <= ptype_d[i];
    if (grant_vld) begin
      mem_key_q[wr_q]  <= grant_idx;
      mem_type_q[wr_q] <= ptype_q[grant_idx];
    end
  end

  // Stage: key FSMs, pending flags, arbiter and FIFO control
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_KEYS; i++) begin
        st_q[i]  <= WAIT_REL;
        cnt_q[i] <= '0;
      end
      pend_q <= '0;
      rr_q   <= '0;
      ovf_q  <= 1'b0;
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      pend_q <= pend_d;
      rr_q   <= rr_d;
      ovf_q  <= ovf_d;
      wr_q   <= wr_q + PTR_W'(grant_vld);
      rd_q   <= rd_q + PTR_W'(pop);
      fcnt_q <= fcnt_q + {{PTR_W{1'b0}}, grant_vld} - {{PTR_W{1'b0}}, pop};
    end
  end

  assign ev_valid    = (fcnt_q != '0);
  assign ev_key      = ev_valid ? mem_key_q[rd_q]  : '0;
  assign ev_type     = ev_valid ? mem_type_q[rd_q] : 2'b00;
  assign ev_overflow = ovf_q;

endmodule
